// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the LEGv8 pipeline hazard controller: sequencer states and
// the per-stage enable/bubble control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} pctrl_state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
        logic exmem_en;
        logic exmem_flush;
        logic memwr_bubble;
    } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline: load-use bubble, MEM-resolved
// branch flush, and multi-cycle dmem freeze with a timeout into a sticky error state.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwr_bubble,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pctrl_state_t      state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              err_q, err_nxt;
    logic              load_use;
    logic              mem_busy;
    stage_ctrl_t       ctrl;

    assign load_use = ex_mem_read && (ex_rd != XZR) &&
                      ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    // mem_busy marks cycles where the whole pipe freezes for the data memory
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_q;
        mem_busy     = 1'b0;
        unique case (state)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    mem_busy     = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    mem_busy     = 1'b1;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ERROR:   mem_busy = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    // Branch outranks load-use: the flush removes the dependent instruction anyway.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            ctrl.ifid_flush   = 1'b1;
            ctrl.idex_bubble  = 1'b1;
            ctrl.exmem_flush  = 1'b1;
            ctrl.memwr_bubble = 1'b1;
        end else if (mem_busy) begin
            ctrl.memwr_bubble = 1'b1;
        end else if (mem_br_taken) begin
            ctrl.pc_en       = 1'b1;
            ctrl.pc_redirect = 1'b1;
            ctrl.ifid_en     = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_en     = 1'b1;
            ctrl.idex_bubble = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (load_use) begin
            ctrl.idex_en     = 1'b1;
            ctrl.idex_bubble = 1'b1;
            ctrl.exmem_en    = 1'b1;
        end else begin
            ctrl.pc_en    = 1'b1;
            ctrl.ifid_en  = 1'b1;
            ctrl.idex_en  = 1'b1;
            ctrl.exmem_en = 1'b1;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign pc_redirect  = ctrl.pc_redirect;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_en     = ctrl.exmem_en;
    assign exmem_flush  = ctrl.exmem_flush;
    assign memwr_bubble = ctrl.memwr_bubble;
    assign err          = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!ctrl.pc_en),
        .q     (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random checks of pipe_hazard_ctrl against a cycle-level behavioural model;
// a second instance with a 3-bit counter exercises saturation.
module tb_pipe_hazard_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rn, id_rm, ex_rd;
    logic        id_uses_rm, ex_mem_read, mem_br_taken, dmem_req, dmem_ack;

    logic        pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic        exmem_en, exmem_flush, memwr_bubble, err;
    logic [31:0] stall_cnt;

    logic        s_pc_en, s_pc_redirect, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble;
    logic        s_exmem_en, s_exmem_flush, s_memwr_bubble, s_err;
    logic [2:0]  s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model: memory-wait flag, completed wait cycles, sticky error, stall tally
    bit m_wait, m_err;
    int m_wcnt, m_stalls;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_br_taken(mem_br_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(pc_en), .pc_redirect(pc_redirect),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwr_bubble(memwr_bubble),
        .err(err), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_br_taken(mem_br_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(s_pc_en), .pc_redirect(s_pc_redirect),
        .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
        .idex_bubble(s_idex_bubble), .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush),
        .memwr_bubble(s_memwr_bubble), .err(s_err), .stall_cnt(s_stall_cnt)
    );

    wire [8:0] obs   = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble,
                        exmem_en, exmem_flush, memwr_bubble};
    wire [8:0] obs_s = {s_pc_en, s_pc_redirect, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble,
                        s_exmem_en, s_exmem_flush, s_memwr_bubble};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // bit order: pc_en pc_redirect ifid_en ifid_flush idex_en idex_bubble exmem_en exmem_flush memwr_bubble
    function automatic logic [8:0] expect_ctrl();
        bit busy, lu;
        if (!reset) return 9'b0_0_0_1_0_1_0_1_1;
        busy = m_err || (m_wait ? !dmem_ack : (dmem_req && !dmem_ack));
        if (busy) return 9'b0_0_0_0_0_0_0_0_1;
        lu = ex_mem_read && (ex_rd != 5'd31) &&
             ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
        if (mem_br_taken) return 9'b1_1_1_1_1_1_1_1_0;
        if (lu)           return 9'b0_0_0_0_1_1_1_0_0;
        return 9'b1_0_1_0_1_0_1_0_0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_wcnt = 0; m_stalls = 0;
    endtask

    task automatic check_now(input string tag);
        logic [8:0] e;
        e = expect_ctrl();
        chk({tag, ".ctrl"},   64'(obs),         64'(e));
        chk({tag, ".ctrl_s"}, 64'(obs_s),       64'(e));
        chk({tag, ".err"},    64'(err),         64'(m_err));
        chk({tag, ".err_s"},  64'(s_err),       64'(m_err));
        chk({tag, ".cnt"},    64'(stall_cnt),   64'(m_stalls));
        chk({tag, ".cnt_s"},  64'(s_stall_cnt), 64'((m_stalls > 7) ? 7 : m_stalls));
    endtask

    // called just after a falling edge with inputs already driven
    task automatic step(input string tag);
        logic [8:0] e;
        if (!reset) model_reset();
        #1;
        check_now(tag);
        e = expect_ctrl();
        @(posedge clk);
        if (reset) begin
            if (!e[8]) m_stalls++;
            if (!m_err) begin
                if (m_wait) begin
                    if (dmem_ack)            m_wait = 0;
                    else if (m_wcnt == T-1)  m_err = 1;
                    else                     m_wcnt++;
                end else if (dmem_req && !dmem_ack) begin
                    m_wait = 1;
                    m_wcnt = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rn, rm, input logic urm, mrd,
                         input logic [4:0] rd, input logic br, req, ack);
        id_rn = rn; id_rm = rm; id_uses_rm = urm; ex_mem_read = mrd;
        ex_rd = rd; mem_br_taken = br; dmem_req = req; dmem_ack = ack;
    endtask

    initial begin
        int c0;
        logic [4:0] regs [4];
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        step("rst0");
        step("rst1");
        reset = 1'b1;
        step("idle");

        // load-use on Rn
        drive(3, 0, 0, 1, 3, 0, 0, 0);
        step("lu_rn");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rn_after");
        chk("lu_cnt", 64'(stall_cnt), 64'd1);

        // XZR destination and unused Rm never stall; used Rm does
        drive(31, 31, 1, 1, 31, 0, 0, 0);
        step("xzr");
        drive(4, 5, 0, 1, 5, 0, 0, 0);
        step("rm_unused");
        drive(4, 5, 1, 1, 5, 0, 0, 0);
        step("rm_used");

        // branch together with load-use
        drive(3, 0, 0, 1, 3, 1, 0, 0);
        step("br_lu");
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("zero_wait");

        // ack three cycles after req
        c0 = m_stalls;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("mw0");
        step("mw1");
        step("mw2");
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        step("mw_ack_br");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_done");
        chk("mw_cnt", 64'(stall_cnt), 64'(c0 + 3));

        // timeout into sticky error
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 1 + T; i++) step("to");
        chk("to_err", 64'(err), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("err_hold0");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("err_hold1");
        reset = 1'b0;
        step("err_rst");
        reset = 1'b1;
        step("err_cleared");

        // async reset in the middle of a memory wait
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("ar0");
        step("ar1");
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_now("ar_async");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("ar_held");
        reset = 1'b1;
        step("ar_run");

        // saturation of the 3-bit counter
        drive(7, 0, 0, 1, 7, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("sat");
        chk("sat_small", 64'(s_stall_cnt), 64'd7);
        chk("sat_wide",  64'(stall_cnt),   64'd9);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset = ((m_err && $urandom_range(0, 2) == 0) || $urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
            id_rn        = regs[$urandom_range(0, 3)];
            id_rm        = regs[$urandom_range(0, 3)];
            ex_rd        = regs[$urandom_range(0, 3)];
            id_uses_rm   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            mem_br_taken = ($urandom_range(0, 4) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ack     = ($urandom_range(0, 2) != 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
